// File: rtl/tuner_pkg.sv
// tuner_pkg: shared types and defaults for the tuner sequencer.
//   seq_state_t   - sequencer FSM states
//   STG_*         - 2-bit stage codes reported on err_stage
//   *_W_DEF       - default widths used by tuner_seq
//   stage_code()  - maps a working state to its stage code
package tuner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FFT   = 3'd2,
    ST_FREQ  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } seq_state_t;

  localparam logic [1:0] STG_NONE = 2'd0;
  localparam logic [1:0] STG_LOAD = 2'd1;
  localparam logic [1:0] STG_FFT  = 2'd2;
  localparam logic [1:0] STG_FREQ = 2'd3;

  localparam int ADDR_W_DEF  = 11;
  localparam int DATA_W_DEF  = 10;
  localparam int RES_W_DEF   = 11;
  localparam int TO_W_DEF    = 16;
  localparam int FRAME_W_DEF = 16;

  function automatic logic [1:0] stage_code(input seq_state_t s);
    case (s)
      ST_LOAD: stage_code = STG_LOAD;
      ST_FFT:  stage_code = STG_FFT;
      ST_FREQ: stage_code = STG_FREQ;
      default: stage_code = STG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// stage_watchdog: per-stage cycle counter.
//   clk, rst  - clock, synchronous active-high reset
//   clear     - restart the count (stage entry)
//   run       - count this cycle (a working stage is active)
//   expired   - this edge brings the count to 2^TO_W-1 while running
module stage_watchdog #(
  parameter int TO_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  // One below all-ones: expiry is flagged combinationally on the cycle whose
  // closing edge would make the count reach 2^TO_W-1.
  localparam logic [TO_W-1:0] LAST = {{(TO_W-1){1'b1}}, 1'b0};

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (run)     cnt <= cnt + 1'b1;
  end

  assign expired = run && (cnt == LAST);

endmodule

// File: rtl/tuner_seq.sv
// tuner_seq: load -> FFT -> frequency-search sequencer owning the shared
// sample memory port.
//   clk, rst                 - clock, synchronous active-high reset
//   start/continuous/abort   - run control
//   busy/done/err/err_stage  - status; frame_cnt counts completed frames
//   load_*/fft_*/ff_*        - stage handshakes and their memory requests
//   mem_*                    - muxed memory port
//   result/result_valid      - last latched peak bin
module tuner_seq
  import tuner_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int TO_W    = TO_W_DEF,
  parameter int FRAME_W = FRAME_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               continuous,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_stage,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               load_go,
  input  logic               load_done,
  input  logic               load_we,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [DATA_W-1:0]  load_wdata,
  output logic               fft_go,
  input  logic               fft_done,
  input  logic               fft_we,
  input  logic [ADDR_W-1:0]  fft_addr,
  input  logic [DATA_W-1:0]  fft_wdata,
  output logic               ff_go,
  input  logic               ff_done,
  input  logic [ADDR_W-1:0]  ff_addr,
  input  logic [RES_W-1:0]   ff_result,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic [RES_W-1:0]   result,
  output logic               result_valid
);

  seq_state_t state_q, state_d;
  logic       in_stage;
  logic       wd_clear;
  logic       wd_expired;
  logic       start_ok;

  assign in_stage = (state_q == ST_LOAD) || (state_q == ST_FFT) || (state_q == ST_FREQ);
  // Any state change restarts the watchdog, so every stage entry starts at 0.
  assign wd_clear = (state_d != state_q);
  assign start_ok = start && !abort && ((state_q == ST_IDLE) || (state_q == ST_ERROR));

  stage_watchdog #(.TO_W(TO_W)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .run     (in_stage),
    .expired (wd_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: abort beats stage done, stage done beats watchdog expiry.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERROR: if (start) state_d = ST_LOAD;
        ST_LOAD: begin
          if (load_done)       state_d = ST_FFT;
          else if (wd_expired) state_d = ST_ERROR;
        end
        ST_FFT: begin
          if (fft_done)        state_d = ST_FREQ;
          else if (wd_expired) state_d = ST_ERROR;
        end
        ST_FREQ: begin
          if (ff_done)         state_d = ST_DONE;
          else if (wd_expired) state_d = ST_ERROR;
        end
        // DONE always lasts one cycle, which gives load_go its low gap.
        ST_DONE: state_d = continuous ? ST_LOAD : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs: pure decode of the registered state
  always_comb begin
    load_go   = (state_q == ST_LOAD);
    fft_go    = (state_q == ST_FFT);
    ff_go     = (state_q == ST_FREQ);
    done      = (state_q == ST_DONE);
    busy      = in_stage || (state_q == ST_DONE);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ST_LOAD: begin
        mem_we    = load_we;
        mem_addr  = load_addr;
        mem_wdata = load_wdata;
      end
      ST_FFT: begin
        mem_we    = fft_we;
        mem_addr  = fft_addr;
        mem_wdata = fft_wdata;
      end
      // Search only reads.
      ST_FREQ: mem_addr = ff_addr;
      default: ;
    endcase
  end

  // Status, result and frame bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      err          <= 1'b0;
      err_stage    <= STG_NONE;
      result       <= '0;
      result_valid <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      if (start_ok) begin
        err       <= 1'b0;
        err_stage <= STG_NONE;
      end else if ((state_d == ST_ERROR) && (state_q != ST_ERROR)) begin
        err       <= 1'b1;
        err_stage <= stage_code(state_q);
      end
      if ((state_q == ST_FREQ) && (state_d == ST_DONE)) begin
        result       <= ff_result;
        result_valid <= 1'b1;
        frame_cnt    <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/tuner_seq.md
# tuner_seq

Top-level sequencer for the tuner datapath: runs load → FFT → frequency search over one shared sample memory, owning that memory's single write/address port. Parametrised successor to the fixed single-shot controller. Adds:
- widths as parameters
- continuous (free-running) mode
- abort
- per-stage watchdog timeout with error reporting
- frame counter and latched frequency result

Sits between the sample loader, `fft`, `find_freq` and `mem`.

## Interface
Parameters:
- `ADDR_W`, 11, memory address width
- `DATA_W`, 10, memory data width
- `RES_W`, 11, frequency-result width
- `TO_W`, 16, watchdog counter width; timeout = 2^TO_W − 1 cycles per stage
- `FRAME_W`, 16, frame counter width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset: synchronous, active-high
- `start`  in  1  begin a run; honoured only in IDLE or ERROR
- `continuous`  in  1  sampled in DONE; 1 = start next frame immediately
- `abort`  in  1  return to IDLE next cycle from any state
- `busy`  out  1  high in LOAD/FFT/FREQ/DONE
- `done`  out  1  one-cycle pulse per completed frame
- `err`  out  1  sticky timeout flag; cleared by `start` or `rst`
- `err_stage`  out  2  stage that timed out: 1 load, 2 fft, 3 freq, 0 none
- `frame_cnt`  out  FRAME_W  completed frames, wraps
- `load_go`  out  1  level; high while in LOAD
- `load_done`  in  1  loader finished
- `load_we`  in  1  loader write enable
- `load_addr`  in  ADDR_W  loader address
- `load_wdata`  in  DATA_W  loader write data
- `fft_go`  out  1  level; high while in FFT
- `fft_done`  in  1  FFT finished
- `fft_we`  in  1  FFT write enable
- `fft_addr`  in  ADDR_W  FFT address
- `fft_wdata`  in  DATA_W  FFT write data
- `ff_go`  out  1  level; high while in FREQ
- `ff_done`  in  1  search finished, `ff_result` valid
- `ff_addr`  in  ADDR_W  search read address
- `ff_result`  in  RES_W  peak bin index
- `mem_we`  out  1  muxed memory write enable
- `mem_addr`  out  ADDR_W  muxed memory address
- `mem_wdata`  out  DATA_W  muxed memory write data
- `result`  out  RES_W  last latched frequency bin
- `result_valid`  out  1  high once any frame has completed

## Operation
States: IDLE, LOAD, FFT, FREQ, DONE, ERROR.

Transitions:
- IDLE + `start` → LOAD.
- LOAD + `load_done` → FFT.
- FFT + `fft_done` → FREQ.
- FREQ + `ff_done` → DONE.
- DONE → LOAD if `continuous`, else IDLE.
- LOAD/FFT/FREQ + watchdog expiry → ERROR.
- ERROR + `start` → LOAD; `err` clears the same edge.

Priority, highest first: `rst` > `abort` > stage done > watchdog expiry. A done and an expiry in the same cycle proceed normally. `start` is ignored while `busy`.

Go signals:
- `*_go` is a pure decode of the registered state; exactly one is high in LOAD/FFT/FREQ, all are low otherwise.
- DONE guarantees at least one low cycle on `load_go` between frames, so the loader re-arms.

Memory mux is combinational from the state:
- LOAD → `load_*`.
- FFT → `fft_*`.
- FREQ → address from `ff_addr`, `mem_we`=0, `mem_wdata`=0.
- All other states → all three outputs 0.

Watchdog:
- Counter clears on every stage entry and increments each cycle in LOAD/FFT/FREQ.
- Reaching 2^TO_W − 1 without the stage's done triggers ERROR, sets `err`, and records `err_stage`.

Result and frame count:
- On the FREQ→DONE edge, `result` ← `ff_result`, `result_valid` ← 1, and `frame_cnt` increments (wrapping to 0).
- Abort mid-FREQ leaves `result`, `result_valid` and `frame_cnt` unchanged.

Abort: state → IDLE, go signals low next cycle, no `done` pulse, `err`/`err_stage` unchanged.

## Timing
Reset values: state IDLE; all outputs 0, including `result`, `result_valid`, `frame_cnt`, `err_stage`.

Cycle-level behaviour:
- `start` sampled at edge N → `load_go`=1 and `busy`=1 from N+1.
- Stage done sampled at edge N → next go high from N+1, current go low from N+1; zero-cycle handoff.
- `ff_done` at edge N → `done`=1 and `result` updated during N+1 (DONE); with `continuous`=1, `load_go`=1 at N+2.
- Minimum frame length is 4 cycles, assuming each stage asserts done in its first cycle.
- Watchdog expiry is observed at the edge where the count reaches 2^TO_W − 1; `err` is visible the following cycle.
- Reset mid-operation takes effect at the next edge regardless of state.

## Structure
- Package `tuner_pkg`: state enum `seq_state_t`, stage codes `STG_NONE`/`STG_LOAD`/`STG_FFT`/`STG_FREQ` (2-bit), shared default widths.
- Sub-module `stage_watchdog`:
  - parameter `TO_W`
  - inputs `clk`, `rst`, `clear`, `run`
  - output `expired`
  - instantiated once.
- Everything else (FSM, mux, result/frame registers) lives in `tuner_seq`.

## Test plan
- **Single frame:** reset, pulse `start`, stages assert done after 3/5/2 cycles with `ff_result`=0x1A3 → exactly one `done`; `result`=0x1A3, `result_valid`=1, `frame_cnt`=1, back to IDLE.
- **Mux:** in LOAD drive `load_we`=1, `load_addr`=5, `load_wdata`=0x2AA → memory port shows the same; in FREQ with `fft_we`=1 → `mem_we`=0 and `mem_addr`=`ff_addr`.
- **Continuous:** hold `continuous`=1 for 3 frames → 3 `done` pulses, `frame_cnt`=3, `load_go` low exactly one cycle between frames.
- **Timeout:** `TO_W`=4, `fft_done` never asserted → ERROR 15 cycles after FFT entry; `err`=1, `err_stage`=2, all go low; then `start` → `err`=0, LOAD.
- **Abort:** `abort` in FFT → IDLE next cycle, no `done`, `frame_cnt` unchanged. `abort` together with `load_done` → IDLE wins.
- **Wrap and reset:** `FRAME_W`=2, run 4 frames → `frame_cnt`=0. `rst` mid-FREQ → all outputs 0 the next cycle.
